crack_dispatch: RTL and testbench

Parametrised key-space dispatcher for the ARC4 cracking datapath. It splits the key range 0..KEY_MAX across NCH independent cracker channels, each of which owns its own S/K/PT memories. Keys are handed out one per free channel over a rdy/en handshake, and the first found key is reported. The block sits between the top-level control (switch/KEY start, HEX display) and the cracker channel array, and replaces the fixed two-cracker arrangement with an N-channel, variable-key-width one.

---
 rtl/crack_dispatch.sv | 139 +++++++++++++
 tb/tb_crack_dispatch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/crack_dispatch.sv
// Key-space dispatcher: hands keys 0..KEY_MAX to NCH cracker channels over a rdy/en
// handshake and reports the first found key. Define CRACK_DISPATCH_STATS_EN for the keys_tried counter.
module crack_dispatch #(
  parameter int             NCH     = 2,
  parameter int             KEY_W   = 24,
  parameter logic [KEY_W:0] KEY_MAX = {1'b0, {KEY_W{1'b1}}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  output logic                   done,
  output logic                   key_valid,
  output logic [KEY_W-1:0]       key,
  output logic [KEY_W:0]         keys_tried,
  output logic [NCH-1:0]         ch_en,
  output logic [NCH*KEY_W-1:0]   ch_key,
  input  logic [NCH-1:0]         ch_rdy,
  input  logic [NCH-1:0]         ch_done,
  input  logic [NCH-1:0]         ch_found
);

  // state | meaning
  // IDLE  | rdy=1, waiting for en; key/key_valid hold the last result
  // RUN   | one key per cycle to the lowest free channel
  // DRAIN | no dispatch; waiting for every busy channel to report
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [KEY_W:0]   next_key;
  logic [NCH-1:0]   busy, busy_nxt;
  logic [NCH-1:0]   done_acc, found_acc, disp;
  logic [KEY_W-1:0] found_key;
  logic             start, found_any, found_take, exhausted, finish;

  assign rdy        = (state == IDLE);
  assign start      = (state == IDLE) && en;
  // results from channels we never started (or already retired) are dropped
  assign done_acc   = (state == IDLE) ? '0 : (ch_done & busy);
  assign found_acc  = done_acc & ch_found;
  assign found_any  = |found_acc;
  assign found_take = found_any && !key_valid;
  assign exhausted  = (next_key > KEY_MAX);

  always_comb begin
    found_key = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (found_acc[i]) found_key = ch_key[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    disp = '0;
    if (state == RUN && !found_any && !exhausted) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (ch_rdy[i] && !busy[i]) begin
          disp    = '0;
          disp[i] = 1'b1;
        end
      end
    end
  end

  assign busy_nxt = start ? '0 : ((busy & ~done_acc) | disp);

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (found_any || exhausted) state_nxt = DRAIN;
      DRAIN:   state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
    // finish on the edge that retires the last busy channel, so done lines up with it
    if (state_nxt == DRAIN && busy_nxt == '0) begin
      state_nxt = IDLE;
      finish    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= '0;
      next_key  <= '0;
      ch_en     <= '0;
      ch_key    <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      ch_en <= disp;
      done  <= finish;
      if (start) begin
        next_key  <= '0;
        key_valid <= 1'b0;
      end else if (|disp) begin
        next_key <= next_key + 1'b1;
      end
      if (found_take) begin
        key       <= found_key;
        key_valid <= 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (disp[i]) ch_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
      end
    end
  end

`ifdef CRACK_DISPATCH_STATS_EN
  logic [4:0]       n_done;
  logic [KEY_W+1:0] tried_sum;

  always_comb begin
    n_done = '0;
    for (int i = 0; i < NCH; i++) n_done = n_done + 5'(done_acc[i]);
  end

  assign tried_sum = {1'b0, keys_tried} + (KEY_W+2)'(n_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_tried <= '0;
    end else if (start) begin
      keys_tried <= '0;
    end else if (tried_sum[KEY_W+1]) begin
      keys_tried <= '1;
    end else begin
      keys_tried <= tried_sum[KEY_W:0];
    end
  end
`else
  assign keys_tried = '0;
`endif

endmodule

// File: tb/tb_crack_dispatch.sv
// Directed bench for crack_dispatch (NCH=2, KEY_W=4) with behavioural cracker channels.
module tb_crack_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy, done, key_valid;
  logic [3:0] key;
  logic [4:0] keys_tried;
  logic [1:0] ch_en;
  logic [7:0] ch_key;
  logic [1:0] ch_rdy   = 2'b11;
  logic [1:0] ch_done  = 2'b00;
  logic [1:0] ch_found = 2'b00;

  crack_dispatch #(.NCH(2), .KEY_W(4), .KEY_MAX(5'd15)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done),
    .key_valid(key_valid), .key(key), .keys_tried(keys_tried),
    .ch_en(ch_en), .ch_key(ch_key), .ch_rdy(ch_rdy),
    .ch_done(ch_done), .ch_found(ch_found)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_tried(input int n);
`ifdef CRACK_DISPATCH_STATS_EN
    return 64'(n);
`else
    return 64'(n - n);
`endif
  endfunction

  // channel model state; each key takes 3 cycles except slow_key, which takes slow_lat
  logic [15:0] found_mask = '0;
  int slow_key = -1;
  int slow_lat = 3;
  int cnt [2];
  int mkey [2];
  int disp_cnt [16];
  int disp_total, first_key, done_pulses, done_cyc, last_chdone_cyc, cyc;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ch_rdy   = 2'b11;
      ch_done  = 2'b00;
      ch_found = 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] = 0;
    end else begin
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      ch_done  = 2'b00;
      ch_found = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            ch_done[i]      = 1'b1;
            ch_found[i]     = found_mask[mkey[i]];
            ch_rdy[i]       = 1'b1;
            last_chdone_cyc = cyc;
          end
        end
        if (ch_en[i]) begin
          mkey[i] = int'(ch_key[i*4 +: 4]);
          if (disp_total == 0) first_key = mkey[i];
          disp_cnt[mkey[i]]++;
          disp_total++;
          cnt[i]    = (mkey[i] == slow_key) ? slow_lat : 3;
          ch_rdy[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic run_search(input logic [15:0] mask, input int skey, input int slat, input int settle);
    int  n;
    int  base;
    logic seen;
    found_mask = mask;
    slow_key   = skey;
    slow_lat   = slat;
    for (int k = 0; k < 16; k++) disp_cnt[k] = 0;
    disp_total = 0;
    first_key  = -1;
    base       = done_pulses;
    en = 1'b1;
    tick;
    en = 1'b0;
    check_val("rdy_low_after_en", rdy, 0);
    check_val("key_valid_cleared_on_en", key_valid, 0);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 400) begin
      tick;
      n++;
      if (done) seen = 1'b1;
    end
    check_val("done_seen", seen, 1);
    check_val("done_after_last_ch_done", done_cyc, last_chdone_cyc + 1);
    check_val("first_key_zero", first_key, 0);
    if (settle > 0) begin
      for (int k = 0; k < settle; k++) tick;
      check_val("single_done_pulse", done_pulses - base, 1);
    end
  endtask

  initial begin
    int n;
    int bad_keys;
    rst = 1'b1;
    en  = 1'b0;
    tick;
    tick;
    check_val("rst_rdy", rdy, 1);
    check_val("rst_done", done, 0);
    check_val("rst_key_valid", key_valid, 0);
    check_val("rst_key", key, 0);
    check_val("rst_keys_tried", keys_tried, 0);
    check_val("rst_ch_en", ch_en, 0);
    check_val("rst_ch_key", ch_key, 0);
    rst = 1'b0;
    tick;

    // found only for key 5: keys 0..5 go out once, nothing after the found
    run_search(16'h0020, -1, 3, 3);
    check_val("found_key", key, 5);
    check_val("found_valid", key_valid, 1);
    check_val("found_disp_total", disp_total, 6);
    bad_keys = 0;
    for (int k = 0; k < 6; k++) if (disp_cnt[k] != 1) bad_keys++;
    check_val("found_keys_once", bad_keys, 0);
    check_val("found_keys_tried", keys_tried, exp_tried(6));

    // keys 6 (ch0, slow) and 7 (ch1) report found in the same cycle: lower index wins
    run_search(16'h00C0, 6, 4, 2);
    check_val("simul_key", key, 6);
    check_val("simul_valid", key_valid, 1);
    check_val("simul_disp_total", disp_total, 8);
    check_val("simul_keys_tried", keys_tried, exp_tried(8));

    // ch0 finds 2 while ch1 holds key 3 for 13 cycles and then also reports found
    run_search(16'h000C, 3, 13, 0);
    check_val("drain_key", key, 2);
    check_val("drain_valid", key_valid, 1);
    check_val("drain_disp_total", disp_total, 4);
    check_val("drain_keys_tried", keys_tried, exp_tried(4));

    // back-to-back start the cycle after done, then run the whole space dry
    tick;
    run_search(16'h0000, -1, 3, 2);
    check_val("exh_valid", key_valid, 0);
    check_val("exh_disp_total", disp_total, 16);
    bad_keys = 0;
    for (int k = 0; k < 16; k++) if (disp_cnt[k] != 1) bad_keys++;
    check_val("exh_keys_once", bad_keys, 0);
    check_val("exh_keys_tried", keys_tried, exp_tried(16));

    // reset in the middle of a search while a ch_en pulse is on the wire
    found_mask = '0;
    slow_key   = -1;
    en = 1'b1;
    tick;
    en = 1'b0;
    n = 0;
    while (ch_en == 2'b00 && n < 20) begin
      tick;
      n++;
    end
    check_val("midrun_ch_en_seen", (ch_en != 2'b00), 1);
    check_val("midrun_rdy_low", rdy, 0);
    #1 rst = 1'b1;
    #1;
    check_val("midrst_rdy", rdy, 1);
    check_val("midrst_ch_en", ch_en, 0);
    check_val("midrst_key_valid", key_valid, 0);
    check_val("midrst_keys_tried", keys_tried, 0);
    check_val("midrst_key", key, 0);
    check_val("midrst_ch_key", ch_key, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    // recovery: found at key 1
    run_search(16'h0002, -1, 3, 2);
    check_val("recov_key", key, 1);
    check_val("recov_valid", key_valid, 1);
    check_val("recov_disp_total", disp_total, 2);
    check_val("recov_keys_tried", keys_tried, exp_tried(2));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
